// File: rtl/brew_seq_pkg.sv
// brew_seq_pkg: stage encoding, progress constants and size helpers for the brew sequencer
package brew_seq_pkg;
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_GRIND  = 3'd1,
    ST_HEAT   = 3'd2,
    ST_PREINF = 3'd3,
    ST_BREW   = 3'd4,
    ST_MILK   = 3'd5,
    ST_FINISH = 3'd6
  } stage_t;
  localparam logic [6:0] PROG_IDLE   = 7'd0;
  localparam logic [6:0] PROG_GRIND  = 7'd10;
  localparam logic [6:0] PROG_HEAT   = 7'd25;
  localparam logic [6:0] PROG_PREINF = 7'd35;
  localparam logic [6:0] PROG_BREW   = 7'd40;
  localparam logic [6:0] PROG_MILK   = 7'd80;
  localparam logic [6:0] PROG_FINISH = 7'd95;
  localparam logic [6:0] PROG_DONE   = 7'd100;
  function automatic logic [1:0] size_mult(input logic [1:0] size);
    return (size == 2'd3) ? 2'd3 : size + 2'd1;
  endfunction
  function automatic logic [6:0] stage_progress(input stage_t s);
    return s == ST_GRIND  ? PROG_GRIND  :
           s == ST_HEAT   ? PROG_HEAT   :
           s == ST_PREINF ? PROG_PREINF :
           s == ST_BREW   ? PROG_BREW   :
           s == ST_MILK   ? PROG_MILK   :
           s == ST_FINISH ? PROG_FINISH : PROG_IDLE;
  endfunction
endpackage

// File: rtl/ms_tick_gen.sv
// ms_tick_gen: free-running TICK_DIV divider emitting a one-cycle tick, with synchronous phase clear
module ms_tick_gen #(
  parameter int unsigned TICK_DIV = 50_000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);
  localparam int unsigned W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  logic [W-1:0] cnt_q, cnt_d;
  assign tick = cnt_q == W'(TICK_DIV - 1);
  // wrap on tick, restart phase on clear
  always_comb cnt_d = (clr || tick) ? '0 : cnt_q + 1'b1;
  // divider counter
  always_ff @(posedge clk) cnt_q <= rst ? '0 : cnt_d;
endmodule

// File: rtl/brew_step_sequencer.sv
// brew_step_sequencer: brew-cycle sequencer driving grinder/heater/pump/milk; BREW_PREINFUSE_EN enables PREINF
module brew_step_sequencer
  import brew_seq_pkg::*;
#(
  parameter int unsigned TICK_DIV        = 50_000,
  parameter int unsigned GRIND_MS        = 3000,
  parameter int unsigned HEAT_TIMEOUT_MS = 10000,
  parameter int unsigned PREINF_MS       = 1000,
  parameter int unsigned BREW_MS         = 2000,
  parameter int unsigned MILK_MS         = 1500,
  parameter int unsigned FINISH_MS       = 500
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [1:0] size,
  input  logic       need_milk,
  input  logic       water_temp_ok,
  input  logic       pressure_ready,
  input  logic       abort,
  output logic       grinder_on,
  output logic       heater_on,
  output logic       pump_on,
  output logic       milk_valve,
  output logic       busy,
  output logic       done,
  output logic       fault,
  output logic [2:0] stage,
  output logic [6:0] progress
);
`ifdef BREW_PREINFUSE_EN
  localparam stage_t HEAT_NEXT = ST_PREINF;
`else
  localparam stage_t HEAT_NEXT = ST_BREW;
`endif
  stage_t      state_q, state_d;
  logic [15:0] timer_q, timer_d, brew_dur_q, brew_dur_d, dur;
  logic        need_milk_q, need_milk_d;
  logic        grinder_q, grinder_d, heater_q, heater_d, pump_q, pump_d, milk_q, milk_d;
  logic        busy_q, busy_d, done_q, done_d, fault_q, fault_d;
  logic [6:0]  progress_q, progress_d;
  logic        tick, accept, expire;
  assign accept = start && state_q == ST_IDLE;
  ms_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (.clk(clk), .rst(rst), .clr(accept), .tick(tick));
  // stage sequencing, timers and registered output decode from the next state
  always_comb begin
    dur = state_q == ST_GRIND  ? 16'(GRIND_MS) :
          state_q == ST_HEAT   ? 16'(HEAT_TIMEOUT_MS) :
          state_q == ST_PREINF ? 16'(PREINF_MS) :
          state_q == ST_BREW   ? brew_dur_q :
          state_q == ST_MILK   ? 16'(MILK_MS) : 16'(FINISH_MS);
    expire = tick && timer_q == dur - 16'd1;
    state_d = state_q;
    done_d = 1'b0;
    fault_d = 1'b0;
    brew_dur_d = accept ? 16'(BREW_MS) * {14'd0, size_mult(size)} : brew_dur_q;
    need_milk_d = accept ? need_milk : need_milk_q;
    case (state_q)
      ST_IDLE:   if (start) state_d = ST_GRIND;
      ST_GRIND:  if (expire) state_d = ST_HEAT;
      ST_HEAT: begin
        if (water_temp_ok && pressure_ready) state_d = HEAT_NEXT;
        else if (expire) begin
          state_d = ST_IDLE;
          fault_d = 1'b1;
        end
      end
`ifdef BREW_PREINFUSE_EN
      ST_PREINF: if (expire) state_d = ST_BREW;
`endif
      ST_BREW:   if (expire) state_d = need_milk_q ? ST_MILK : ST_FINISH;
      ST_MILK:   if (expire) state_d = ST_FINISH;
      ST_FINISH: begin
        if (expire) begin
          state_d = ST_IDLE;
          done_d = 1'b1;
        end
      end
      default:   state_d = ST_IDLE;
    endcase
    if (abort && state_q != ST_IDLE) begin
      state_d = ST_IDLE;
      fault_d = 1'b1;
      done_d = 1'b0;
    end
    timer_d = (state_d != state_q) ? 16'd0 : tick ? timer_q + 16'd1 : timer_q;
    grinder_d = state_d == ST_GRIND;
    heater_d = state_d == ST_HEAT || state_d == ST_PREINF || state_d == ST_BREW;
    pump_d = state_d == ST_PREINF || state_d == ST_BREW;
    milk_d = state_d == ST_MILK;
    busy_d = state_d != ST_IDLE;
    progress_d = state_d != ST_IDLE ? stage_progress(state_d) :
                 done_d ? PROG_DONE : fault_d ? PROG_IDLE : progress_q;
  end
  // state and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      timer_q <= '0;
      brew_dur_q <= '0;
      need_milk_q <= 1'b0;
      grinder_q <= 1'b0;
      heater_q <= 1'b0;
      pump_q <= 1'b0;
      milk_q <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      fault_q <= 1'b0;
      progress_q <= '0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      brew_dur_q <= brew_dur_d;
      need_milk_q <= need_milk_d;
      grinder_q <= grinder_d;
      heater_q <= heater_d;
      pump_q <= pump_d;
      milk_q <= milk_d;
      busy_q <= busy_d;
      done_q <= done_d;
      fault_q <= fault_d;
      progress_q <= progress_d;
    end
  end
  assign grinder_on = grinder_q;
  assign heater_on = heater_q;
  assign pump_on = pump_q;
  assign milk_valve = milk_q;
  assign busy = busy_q;
  assign done = done_q;
  assign fault = fault_q;
  assign stage = state_q;
  assign progress = progress_q;
endmodule

// File: tb/tb_brew_step_sequencer.sv
// tb_brew_step_sequencer: scoreboard bench; driver queues expected stage events, monitor checks them
module tb_brew_step_sequencer;
  localparam int TD = 4, GR = 3, HT = 6, PI = 2, BR = 2, MK = 3, FN = 2;
`ifdef BREW_PREINFUSE_EN
  localparam bit PRE = 1'b1;
`else
  localparam bit PRE = 1'b0;
`endif
  localparam logic [2:0] S_IDLE = 3'd0, S_GRIND = 3'd1, S_HEAT = 3'd2, S_PREINF = 3'd3;
  localparam logic [2:0] S_BREW = 3'd4, S_MILK = 3'd5, S_FINISH = 3'd6;

  logic clk = 1'b0, rst = 1'b1, start = 1'b0, need_milk = 1'b0, abort = 1'b0;
  logic water_temp_ok = 1'b1, pressure_ready = 1'b1;
  logic [1:0] size = 2'd0;
  logic grinder_on, heater_on, pump_on, milk_valve, busy, done, fault;
  logic [2:0] stage;
  logic [6:0] progress;

  typedef struct packed {
    logic [2:0] stg;
    logic [3:0] act;
    logic       busy;
    logic [6:0] prog;
    logic       done;
    logic       fault;
  } obs_t;

  obs_t exp_q[$];
  int dwell_q[$];
  int tests = 0, fails = 0, cyc = 0, last_cyc = 0;
  bit mon_en = 1'b0;
  logic [2:0] prev_stage = 3'd0;

  brew_step_sequencer #(
    .TICK_DIV(TD), .GRIND_MS(GR), .HEAT_TIMEOUT_MS(HT), .PREINF_MS(PI),
    .BREW_MS(BR), .MILK_MS(MK), .FINISH_MS(FN)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .size(size), .need_milk(need_milk),
    .water_temp_ok(water_temp_ok), .pressure_ready(pressure_ready), .abort(abort),
    .grinder_on(grinder_on), .heater_on(heater_on), .pump_on(pump_on), .milk_valve(milk_valve),
    .busy(busy), .done(done), .fault(fault), .stage(stage), .progress(progress)
  );

  always #5 clk = ~clk;

  function automatic logic [3:0] act_of(input logic [2:0] s);
    return s == S_GRIND ? 4'b1000 : s == S_HEAT ? 4'b0100 :
           (s == S_PREINF || s == S_BREW) ? 4'b0110 : s == S_MILK ? 4'b0001 : 4'b0000;
  endfunction

  function automatic logic [6:0] prog_of(input logic [2:0] s);
    return s == S_GRIND ? 7'd10 : s == S_HEAT ? 7'd25 : s == S_PREINF ? 7'd35 :
           s == S_BREW ? 7'd40 : s == S_MILK ? 7'd80 : s == S_FINISH ? 7'd95 : 7'd0;
  endfunction

  task automatic push(input logic [2:0] s, input int dw, input logic [6:0] p, input logic d, input logic f);
    obs_t o;
    o.stg = s;
    o.act = act_of(s);
    o.busy = s != S_IDLE;
    o.prog = p;
    o.done = d;
    o.fault = f;
    exp_q.push_back(o);
    dwell_q.push_back(dw);
  endtask

  task automatic ev(input logic [2:0] s, input int dw);
    push(s, dw, prog_of(s), 1'b0, 1'b0);
  endtask

  task automatic pulse_start(input logic [1:0] sz, input logic mk, input logic ab);
    @(negedge clk);
    start = 1'b1;
    size = sz;
    need_milk = mk;
    abort = ab;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
  endtask

  task automatic wait_stage(input logic [2:0] s, input string nm);
    for (int i = 0; i < 400; i++) begin
      if (stage == s) return;
      @(negedge clk);
    end
    tests++;
    fails++;
    $display("FAIL wait_%s stage=%0d required=%0d", nm, stage, s);
  endtask

  task automatic drain(input string nm);
    for (int i = 0; i < 400 && exp_q.size() != 0; i++) @(negedge clk);
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL drain_%s pending=%0d required=0", nm, exp_q.size());
      exp_q.delete();
      dwell_q.delete();
    end
    repeat (3) @(negedge clk);
  endtask

  always @(negedge clk) begin
    obs_t o, e;
    int dw;
    cyc++;
    o = {stage, grinder_on, heater_on, pump_on, milk_valve, busy, progress, done, fault};
    if (mon_en) begin
      tests++;
      if (o.act !== act_of(o.stg) || o.busy !== (o.stg != S_IDLE) || (o.done && o.fault)) begin
        fails++;
        $display("FAIL invariant cyc=%0d stage=%0d act=%b busy=%b done=%b fault=%b required act=%b", cyc, o.stg, o.act, o.busy, o.done, o.fault, act_of(o.stg));
      end
      if (o.stg != prev_stage || o.done || o.fault) begin
        tests++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL unexpected_event cyc=%0d stage=%0d done=%b fault=%b prog=%0d required none", cyc, o.stg, o.done, o.fault, o.prog);
        end else begin
          e = exp_q.pop_front();
          dw = dwell_q.pop_front();
          if (o !== e || (dw != 0 && cyc - last_cyc != dw)) begin
            fails++;
            $display("FAIL event cyc=%0d got stage=%0d act=%b busy=%b prog=%0d done=%b fault=%b dwell=%0d required stage=%0d act=%b busy=%b prog=%0d done=%b fault=%b dwell=%0d",
                     cyc, o.stg, o.act, o.busy, o.prog, o.done, o.fault, cyc - last_cyc,
                     e.stg, e.act, e.busy, e.prog, e.done, e.fault, dw);
          end
        end
        last_cyc = cyc;
      end
    end
    prev_stage = o.stg;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    tests++;
    if ({grinder_on, heater_on, pump_on, milk_valve, busy, done, fault} !== 7'd0 || stage !== 3'd0 || progress !== 7'd0) begin
      fails++;
      $display("FAIL reset outs=%b stage=%0d prog=%0d required all zero", {grinder_on, heater_on, pump_on, milk_valve, busy, done, fault}, stage, progress);
    end
    rst = 1'b0;
    mon_en = 1'b1;

    // small, no milk
    ev(S_GRIND, 0); ev(S_HEAT, 12);
    if (PRE) begin ev(S_PREINF, 1); ev(S_BREW, 7); end else ev(S_BREW, 1);
    ev(S_FINISH, PRE ? 8 : 7);
    push(S_IDLE, 8, 7'd100, 1'b1, 1'b0);
    pulse_start(2'd0, 1'b0, 1'b0);
    drain("small");
    tests++;
    if (progress !== 7'd100 || busy !== 1'b0) begin
      fails++;
      $display("FAIL progress_hold prog=%0d busy=%b required prog=100 busy=0", progress, busy);
    end

    // large with milk; a start during GRIND and temp loss during BREW must change nothing
    ev(S_GRIND, 0); ev(S_HEAT, 12);
    if (PRE) begin ev(S_PREINF, 1); ev(S_BREW, 7); end else ev(S_BREW, 1);
    ev(S_MILK, PRE ? 24 : 23); ev(S_FINISH, 12);
    push(S_IDLE, 8, 7'd100, 1'b1, 1'b0);
    pulse_start(2'd2, 1'b1, 1'b0);
    wait_stage(S_GRIND, "grind_large");
    pulse_start(2'd0, 1'b0, 1'b0);
    wait_stage(S_BREW, "brew_large");
    water_temp_ok = 1'b0;
    pressure_ready = 1'b0;
    drain("large_milk");
    water_temp_ok = 1'b1;
    pressure_ready = 1'b1;

    // heat timeout
    water_temp_ok = 1'b0;
    ev(S_GRIND, 0); ev(S_HEAT, 12);
    push(S_IDLE, 24, 7'd0, 1'b0, 1'b1);
    pulse_start(2'd1, 1'b0, 1'b0);
    drain("heat_timeout");
    water_temp_ok = 1'b1;

    // abort mid-BREW
    ev(S_GRIND, 0); ev(S_HEAT, 12);
    if (PRE) begin ev(S_PREINF, 1); ev(S_BREW, 7); end else ev(S_BREW, 1);
    push(S_IDLE, 4, 7'd0, 1'b0, 1'b1);
    pulse_start(2'd2, 1'b0, 1'b0);
    wait_stage(S_BREW, "brew_abort");
    repeat (3) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    drain("abort");

    // reset mid-GRIND
    ev(S_GRIND, 0);
    push(S_IDLE, 3, 7'd0, 1'b0, 1'b0);
    pulse_start(2'd0, 1'b0, 1'b0);
    wait_stage(S_GRIND, "grind_rst");
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    drain("reset");

    // restart with start and abort in the same IDLE cycle: start wins
    ev(S_GRIND, 0); ev(S_HEAT, 12);
    if (PRE) begin ev(S_PREINF, 1); ev(S_BREW, 7); end else ev(S_BREW, 1);
    ev(S_FINISH, PRE ? 8 : 7);
    push(S_IDLE, 8, 7'd100, 1'b1, 1'b0);
    pulse_start(2'd0, 1'b0, 1'b1);
    drain("restart");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
